// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOR) between NUM_REQ requesters.
// Optional per-requester grant counters are enabled with the LOGIC_ARB_STATS_EN macro.
module logic_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id
`ifdef LOGIC_ARB_STATS_EN
    ,
    input  logic                     stat_clear,
    output logic [16*NUM_REQ-1:0]    stat_grants
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              can_accept;
    logic              fire;
    logic [WIDTH-1:0]  op_res [NUM_REQ];

    // Every requester's result is computed in parallel; the grant selects one.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_op
        always_comb begin
            case (req_op[2*gi +: 2])
                2'b00:   op_res[gi] = req_a[WIDTH*gi +: WIDTH] & req_b[WIDTH*gi +: WIDTH];
                2'b01:   op_res[gi] = req_a[WIDTH*gi +: WIDTH] | req_b[WIDTH*gi +: WIDTH];
                2'b10:   op_res[gi] = req_a[WIDTH*gi +: WIDTH] ^ req_b[WIDTH*gi +: WIDTH];
                default: op_res[gi] = ~(req_a[WIDTH*gi +: WIDTH] | req_b[WIDTH*gi +: WIDTH]);
            endcase
        end
    end

    // Scan starting at rr_ptr and wrap; the first valid requester wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign can_accept = (state_q == IDLE) | resp_ready;
    assign fire       = reset_n & grant_found & can_accept;
    assign req_ready  = fire ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        if (fire) begin
            state_d     = FULL;
            resp_data_d = op_res[grant_idx];
            resp_id_d   = grant_idx;
            rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (state_q == FULL && resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;

`ifdef LOGIC_ARB_STATS_EN
    // Clear takes priority over a coincident fire; counters saturate at all-ones.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        logic [15:0] cnt_q;
        always_ff @(posedge clock) begin
            if (!reset_n || stat_clear) begin
                cnt_q <= '0;
            end else if (fire && grant_idx == ID_W'(gi) && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign stat_grants[16*gi +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (4 requesters, 32-bit).
// Stats counters are exercised only when LOGIC_ARB_STATS_EN is defined.
module tb_logic_unit_arbiter;

    logic         clock;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_data;
    logic [1:0]   resp_id;
`ifdef LOGIC_ARB_STATS_EN
    logic         stat_clear;
    logic [63:0]  stat_grants;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_res [4];

    logic_unit_arbiter #(.NUM_REQ(4), .WIDTH(32), .ID_W(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .stat_clear (stat_clear),
        .stat_grants(stat_grants)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*i +: 2] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic check_resp(input string tag, input logic [1:0] id, input logic [31:0] data);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_id"},    32'(resp_id),    32'(id));
        check({tag, "_data"},  resp_data,       data);
        $display("txn %s: id=%0d data=%h", tag, resp_id, resp_data);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
`ifdef LOGIC_ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        // Per-requester defaults: 0 AND, 1 OR, 2 XOR, 3 NOR
        set_req(0, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F);
        set_req(1, 2'b01, 32'h1234_0000, 32'h0000_5678);
        set_req(2, 2'b10, 32'hAAAA_5555, 32'hFFFF_0000);
        set_req(3, 2'b11, 32'hF0F0_0000, 32'h0000_0F0F);
        exp_res[0] = 32'h0F0F_0000;
        exp_res[1] = 32'h1234_5678;
        exp_res[2] = 32'h5555_5555;
        exp_res[3] = 32'h0F0F_F0F0;

        // 1. Reset with all requesters valid
        step();
        step();
        settle();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_id", 32'(resp_id), 32'h0);

        reset_n = 1'b1;
        settle();
        check("first_grant", 32'(req_ready), 32'h1);
        step();
        check_resp("first_resp", 2'd0, exp_res[0]);

        // 2. Single requester, all four ops (back-to-back, rr_ptr now 1)
        req_valid = 4'b0100;
        set_req(2, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F);
        settle();
        check("or_ready", 32'(req_ready), 32'h4);
        step();
        check_resp("or", 2'd2, 32'hF0F0_0F0F);

        set_req(2, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F);
        settle();
        check("and_ready", 32'(req_ready), 32'h4);
        step();
        check_resp("and", 2'd2, 32'h0F0F_0000);

        set_req(2, 2'b10, 32'hAAAA_5555, 32'hFFFF_0000);
        step();
        check_resp("xor", 2'd2, 32'h5555_5555);

        set_req(2, 2'b11, 32'hF0F0_0000, 32'h0000_0F0F);
        step();
        check_resp("nor", 2'd2, 32'h0F0F_F0F0);

        // Drain with no requests: output empties and rr_ptr stays at 3
        req_valid = 4'b0000;
        settle();
        check("idle_ready", 32'(req_ready), 32'h0);
        step();
        check("drain_valid", 32'(resp_valid), 32'h0);
        step();
        req_valid = 4'hF;
        settle();
        check("ptr_kept", 32'(req_ready), 32'h8);
        set_req(2, 2'b10, 32'hAAAA_5555, 32'hFFFF_0000);

        // 3. Round-robin from a fresh reset
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        settle();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step();
            check_resp($sformatf("rr%0d", k), 2'(k % 4), exp_res[k % 4]);
        end

        // 4. Backpressure: result from requester 1 held for 3 cycles
        resp_ready = 1'b0;
        req_valid  = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
            step();
            check_resp($sformatf("bp_hold%0d", k), 2'd1, exp_res[1]);
        end
        resp_ready = 1'b1;
        settle();
        check("bp_release_ready", 32'(req_ready), 32'h1);
        step();
        check_resp("bp_next", 2'd0, exp_res[0]);

        // 5. Mid-operation reset
        req_valid = 4'b0010;
        settle();
        check("mr_ready", 32'(req_ready), 32'h2);
        step();
        check_resp("mr_fire", 2'd1, exp_res[1]);
        reset_n   = 1'b0;
        req_valid = 4'b0011;
        settle();
        check("mr_rst_ready", 32'(req_ready), 32'h0);
        step();
        check("mr_valid", 32'(resp_valid), 32'h0);
        check("mr_data", resp_data, 32'h0);
        reset_n = 1'b1;
        settle();
        check("mr_grant", 32'(req_ready), 32'h1);
        step();
        check_resp("mr_resp", 2'd0, exp_res[0]);

`ifdef LOGIC_ARB_STATS_EN
        // 6. Saturating counter and clear
        req_valid = 4'b1000;
        for (int k = 0; k < 70000; k++) begin
            step();
        end
        check("stat_sat", 32'(stat_grants[63:48]), 32'h0000_FFFF);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        req_valid  = 4'b0000;
        check("stat_clr_lo", stat_grants[31:0], 32'h0);
        check("stat_clr_hi", stat_grants[63:32], 32'h0);
`endif

        req_valid = 4'b0000;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
